// File: rtl/rv_decode_pkg.sv
// Shared RV32I encodings for the decode/execute slice: opcodes, funct3 codes,
// ALU operation codes, writeback selects and load sizes.
package rv_decode_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND,
    ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU
  } alu_op_e;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  typedef enum logic [1:0] {LS_NONE, LS_B, LS_H, LS_W} ls_size_e;

endpackage

// File: rtl/lsu_align.sv
// Store lane steering/strobes and one-cycle-latency load extraction/extension.
module lsu_align
  import rv_decode_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2_val,
  input  logic [31:0] mdatai,
  output logic [31:0] mdatao,
  output logic [3:0]  mwstb,
  output logic [31:0] load_data
);

  ls_size_e   ld_size_d, ld_size_q;
  logic       ld_sign_d, ld_sign_q;
  logic [1:0] ld_off_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store data replication and byte strobes; misaligned accesses write nothing
  always_comb begin
    mdatao = rs2_val;
    mwstb  = 4'b0000;
    if (is_store) begin
      case (funct3)
        F3_B: begin
          mdatao = {4{rs2_val[7:0]}};
          mwstb  = 4'(4'b0001 << addr_lo);
        end
        F3_H: begin
          mdatao = {2{rs2_val[15:0]}};
          if (!addr_lo[0]) mwstb = addr_lo[1] ? 4'b1100 : 4'b0011;
        end
        F3_W: begin
          if (addr_lo == 2'b00) mwstb = 4'b1111;
        end
        default: mwstb = 4'b0000;
      endcase
    end
  end

  always_comb begin
    ld_size_d = LS_NONE;
    ld_sign_d = 1'b0;
    if (is_load) begin
      case (funct3)
        F3_B:    begin ld_size_d = LS_B; ld_sign_d = 1'b1; end
        F3_BU:   ld_size_d = LS_B;
        F3_H:    begin ld_size_d = LS_H; ld_sign_d = 1'b1; end
        F3_HU:   ld_size_d = LS_H;
        F3_W:    ld_size_d = LS_W;
        default: ld_size_d = LS_NONE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ld_size_q <= LS_NONE;
      ld_sign_q <= 1'b0;
      ld_off_q  <= 2'b00;
    end else begin
      ld_size_q <= ld_size_d;
      ld_sign_q <= ld_sign_d;
      ld_off_q  <= addr_lo;
    end
  end

  // Extract the addressed lane from the returned word
  always_comb begin
    case (ld_off_q)
      2'd0:    byte_sel = mdatai[7:0];
      2'd1:    byte_sel = mdatai[15:8];
      2'd2:    byte_sel = mdatai[23:16];
      default: byte_sel = mdatai[31:24];
    endcase
    half_sel = ld_off_q[1] ? mdatai[31:16] : mdatai[15:0];
  end

  always_comb begin
    load_data = 32'h0;
    case (ld_size_q)
      LS_B: load_data = {{24{ld_sign_q & byte_sel[7]}}, byte_sel};
      LS_H: if (!ld_off_q[0]) load_data = {{16{ld_sign_q & half_sel[15]}}, half_sel};
      LS_W: if (ld_off_q == 2'b00) load_data = mdatai;
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/rv_decode_execute.sv
// RV32I decode + ALU + branch resolution stage; load/store alignment lives in lsu_align.
module rv_decode_execute
  import rv_decode_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE = 32'h0010_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IR,
  input  logic [31:0] PC,
  input  logic [31:0] RS1_VAL,
  input  logic [31:0] RS2_VAL,
  input  logic [31:0] MDATAI,
  output logic [4:0]  RS1_NUM,
  output logic [4:0]  RS2_NUM,
  output logic [4:0]  RD_NUM,
  output logic [31:0] IMM,
  output logic [31:0] ALU_Y,
  output logic [1:0]  WB_SEL,
  output logic        BR_TAKEN,
  output logic [31:0] BR_ADDR,
  output logic [29:0] MADDR,
  output logic [31:0] MDATAO,
  output logic [3:0]  MWSTB,
  output logic        MCE,
  output logic [31:0] LOAD_DATA
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_load, is_store;
  alu_op_e    alu_op;
  logic [31:0] op_a, op_b;

  assign opcode  = IR[6:0];
  assign funct3  = IR[14:12];
  assign RS1_NUM = IR[19:15];
  assign RS2_NUM = IR[24:20];
  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);

  // Immediate, writeback, destination and ALU-op decode; unknown opcodes fall through as NOP
  always_comb begin
    IMM    = 32'h0;
    RD_NUM = 5'd0;
    WB_SEL = WB_ALU;
    alu_op = ALU_ADD;
    op_a   = RS1_VAL;
    op_b   = IMM;
    case (opcode)
      OPC_LUI:    begin IMM = {IR[31:12], 12'h0}; RD_NUM = IR[11:7]; op_a = 32'h0; end
      OPC_AUIPC:  begin IMM = {IR[31:12], 12'h0}; RD_NUM = IR[11:7]; op_a = PC; end
      OPC_JAL: begin
        IMM    = {{11{IR[31]}}, IR[31], IR[19:12], IR[20], IR[30:21], 1'b0};
        RD_NUM = IR[11:7];
        WB_SEL = WB_PC4;
      end
      OPC_JALR: begin
        IMM    = {{20{IR[31]}}, IR[31:20]};
        RD_NUM = IR[11:7];
        WB_SEL = WB_PC4;
      end
      OPC_BRANCH: begin
        IMM = {{19{IR[31]}}, IR[31], IR[7], IR[30:25], IR[11:8], 1'b0};
        case (funct3)
          F3_BEQ:  alu_op = ALU_EQ;
          F3_BNE:  alu_op = ALU_NE;
          F3_BLT:  alu_op = ALU_LT;
          F3_BGE:  alu_op = ALU_GE;
          F3_BLTU: alu_op = ALU_LTU;
          F3_BGEU: alu_op = ALU_GEU;
          default: alu_op = ALU_EQ;
        endcase
      end
      OPC_LOAD: begin
        IMM    = {{20{IR[31]}}, IR[31:20]};
        RD_NUM = IR[11:7];
        WB_SEL = WB_LOAD;
      end
      OPC_STORE:  IMM = {{20{IR[31]}}, IR[31:25], IR[11:7]};
      OPC_OP_IMM, OPC_OP: begin
        if (opcode == OPC_OP_IMM) IMM = {{20{IR[31]}}, IR[31:20]};
        RD_NUM = IR[11:7];
        case (funct3)
          F3_ADD:  alu_op = (opcode == OPC_OP && IR[30]) ? ALU_SUB : ALU_ADD;
          F3_SLL:  alu_op = ALU_SLL;
          F3_SLT:  alu_op = ALU_SLT;
          F3_SLTU: alu_op = ALU_SLTU;
          F3_XOR:  alu_op = ALU_XOR;
          F3_SR:   alu_op = IR[30] ? ALU_SRA : ALU_SRL;
          F3_OR:   alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      default: ;
    endcase
    op_b = (opcode == OPC_OP || opcode == OPC_BRANCH) ? RS2_VAL : IMM;
  end

  always_comb begin
    ALU_Y = 32'h0;
    case (alu_op)
      ALU_ADD:  ALU_Y = op_a + op_b;
      ALU_SUB:  ALU_Y = op_a - op_b;
      ALU_SLT:  ALU_Y = {31'h0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: ALU_Y = {31'h0, op_a < op_b};
      ALU_XOR:  ALU_Y = op_a ^ op_b;
      ALU_OR:   ALU_Y = op_a | op_b;
      ALU_AND:  ALU_Y = op_a & op_b;
      ALU_SLL:  ALU_Y = op_a << op_b[4:0];
      ALU_SRL:  ALU_Y = op_a >> op_b[4:0];
      ALU_SRA:  ALU_Y = 32'($signed(op_a) >>> op_b[4:0]);
      ALU_EQ:   ALU_Y = {31'h0, op_a == op_b};
      ALU_NE:   ALU_Y = {31'h0, op_a != op_b};
      ALU_LT:   ALU_Y = {31'h0, $signed(op_a) < $signed(op_b)};
      ALU_GE:   ALU_Y = {31'h0, $signed(op_a) >= $signed(op_b)};
      ALU_LTU:  ALU_Y = {31'h0, op_a < op_b};
      ALU_GEU:  ALU_Y = {31'h0, op_a >= op_b};
      default:  ALU_Y = 32'h0;
    endcase
  end

  assign BR_TAKEN = (opcode == OPC_JAL) || (opcode == OPC_JALR) ||
                    ((opcode == OPC_BRANCH) && ALU_Y[0]);
  assign BR_ADDR  = (opcode == OPC_JALR) ? {ALU_Y[31:1], 1'b0} : PC + IMM;
  assign MADDR    = ALU_Y[31:2];
  assign MCE      = (is_load || is_store) && (ALU_Y[31:20] == DMEM_BASE[31:20]);

  lsu_align u_lsu_align (
    .CLK       (CLK),
    .RST       (RST),
    .is_load   (is_load),
    .is_store  (is_store),
    .funct3    (funct3),
    .addr_lo   (ALU_Y[1:0]),
    .rs2_val   (RS2_VAL),
    .mdatai    (MDATAI),
    .mdatao    (MDATAO),
    .mwstb     (MWSTB),
    .load_data (LOAD_DATA)
  );

endmodule

// File: tb/tb_rv_decode_execute.sv
// Directed-vector bench for rv_decode_execute with hand-computed expectations.
module tb_rv_decode_execute;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] IR, PC, RS1_VAL, RS2_VAL, MDATAI;
  logic [4:0]  RS1_NUM, RS2_NUM, RD_NUM;
  logic [31:0] IMM, ALU_Y, BR_ADDR, MDATAO, LOAD_DATA;
  logic [1:0]  WB_SEL;
  logic        BR_TAKEN, MCE;
  logic [29:0] MADDR;
  logic [3:0]  MWSTB;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  rv_decode_execute dut (
    .CLK(CLK), .RST(RST), .IR(IR), .PC(PC), .RS1_VAL(RS1_VAL), .RS2_VAL(RS2_VAL),
    .MDATAI(MDATAI), .RS1_NUM(RS1_NUM), .RS2_NUM(RS2_NUM), .RD_NUM(RD_NUM),
    .IMM(IMM), .ALU_Y(ALU_Y), .WB_SEL(WB_SEL), .BR_TAKEN(BR_TAKEN), .BR_ADDR(BR_ADDR),
    .MADDR(MADDR), .MDATAO(MDATAO), .MWSTB(MWSTB), .MCE(MCE), .LOAD_DATA(LOAD_DATA)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    @(negedge CLK);
    IR = ir; PC = pc; RS1_VAL = r1; RS2_VAL = r2;
    #1;
  endtask

  // Present a load, let it register on the next edge, then supply the memory word
  task automatic do_load(input logic [31:0] ir, input logic [31:0] r1, input logic [31:0] mem);
    drive(ir, 32'h0, r1, 32'h0);
    @(posedge CLK);
    #1;
    MDATAI = mem;
    #1;
  endtask

  initial begin
    RST = 1'b1; IR = 32'h0; PC = 32'h0; RS1_VAL = 32'h0; RS2_VAL = 32'h0;
    MDATAI = 32'hFFFF_FFFF;
    #2;
    chk("reset_load_data", LOAD_DATA, 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    drive(32'h00500093, 32'h0, 32'd10, 32'h0);   // ADDI x1,x0,5
    chk("addi_rd", 32'(RD_NUM), 32'd1);
    chk("addi_imm", IMM, 32'd5);
    chk("addi_alu", ALU_Y, 32'd15);
    chk("addi_wb", 32'(WB_SEL), 32'd0);
    chk("addi_mce", 32'(MCE), 32'd0);
    chk("addi_rs1num", 32'(RS1_NUM), 32'd0);

    drive(32'h402081B3, 32'h0, 32'd5, 32'd7);    // SUB x3,x1,x2
    chk("sub_alu", ALU_Y, 32'hFFFF_FFFE);
    chk("sub_rd", 32'(RD_NUM), 32'd3);
    chk("sub_imm", IMM, 32'h0);
    chk("sub_rsnums", {22'h0, RS2_NUM, RS1_NUM}, {22'h0, 5'd2, 5'd1});

    drive(32'h00208463, 32'h100, 32'd3, 32'd3);  // BEQ x1,x2,+8
    chk("beq_taken", 32'(BR_TAKEN), 32'd1);
    chk("beq_addr", BR_ADDR, 32'h108);
    chk("beq_rd", 32'(RD_NUM), 32'd0);
    drive(32'h00208463, 32'h100, 32'd3, 32'd4);
    chk("beq_not_taken", 32'(BR_TAKEN), 32'd0);

    drive(32'h002080A3, 32'h0, 32'h0010_0000, 32'hAB);  // SB x2,1(x1)
    chk("sb_maddr", 32'(MADDR), 32'h0004_0000);
    chk("sb_wstb", 32'(MWSTB), 32'b0010);
    chk("sb_data", MDATAO, 32'hABAB_ABAB);
    chk("sb_mce", 32'(MCE), 32'd1);
    chk("sb_rd", 32'(RD_NUM), 32'd0);

    drive(32'h0020A023, 32'h0, 32'h0010_0000, 32'h1234_5678);  // SW x2,0(x1)
    chk("sw_wstb", 32'(MWSTB), 32'b1111);
    chk("sw_data", MDATAO, 32'h1234_5678);
    drive(32'h0020A123, 32'h0, 32'h0010_0000, 32'h1234_5678);  // SW x2,2(x1)
    chk("sw_misaligned_wstb", 32'(MWSTB), 32'b0000);

    drive(32'h4040D093, 32'h0, 32'h8000_0000, 32'h0);  // SRAI x1,x1,4
    chk("srai_alu", ALU_Y, 32'hF800_0000);
    chk("srai_imm", IMM, 32'h0000_0404);

    drive(32'h12345137, 32'h0, 32'hDEAD_BEEF, 32'h0);  // LUI x2,0x12345
    chk("lui_alu", ALU_Y, 32'h1234_5000);
    chk("lui_rd", 32'(RD_NUM), 32'd2);
    drive(32'h00001117, 32'h100, 32'hDEAD_BEEF, 32'h0);  // AUIPC x2,1
    chk("auipc_alu", ALU_Y, 32'h0000_1100);

    drive(32'h010000EF, 32'h100, 32'h0, 32'h0);  // JAL x1,+16
    chk("jal_taken", 32'(BR_TAKEN), 32'd1);
    chk("jal_addr", BR_ADDR, 32'h110);
    chk("jal_wb", 32'(WB_SEL), 32'd2);

    drive(32'h000280E7, 32'h200, 32'h1001, 32'h0);  // JALR x1,0(x5)
    chk("jalr_addr", BR_ADDR, 32'h1000);
    chk("jalr_wb", 32'(WB_SEL), 32'd2);
    chk("jalr_taken", 32'(BR_TAKEN), 32'd1);
    chk("jalr_rd", 32'(RD_NUM), 32'd1);

    drive(32'h0000008F, 32'h0, 32'h0010_0000, 32'h0);  // unsupported opcode -> NOP
    chk("nop_rd", 32'(RD_NUM), 32'd0);
    chk("nop_ctrl", {29'h0, MCE, BR_TAKEN, |MWSTB}, 32'h0);

    do_load(32'h00209283, 32'h0010_0000, 32'h8001_1234);  // LH x5,2(x1)
    chk("lh_data", LOAD_DATA, 32'hFFFF_8001);
    do_load(32'h0020D283, 32'h0010_0000, 32'h8001_1234);  // LHU x5,2(x1)
    chk("lhu_data", LOAD_DATA, 32'h0000_8001);
    do_load(32'h00308283, 32'h0010_0000, 32'h8001_1234);  // LB x5,3(x1)
    chk("lb_data", LOAD_DATA, 32'hFFFF_FF80);
    do_load(32'h0010A283, 32'h0010_0000, 32'h8001_1234);  // LW x5,1(x1) misaligned
    chk("lw_misaligned", LOAD_DATA, 32'h0);

    drive(32'h00209283, 32'h0, 32'h0010_0000, 32'h0);  // LH decode fields
    chk("lh_wb", 32'(WB_SEL), 32'd1);
    chk("lh_mce", 32'(MCE), 32'd1);
    do_load(32'h00209283, 32'h0010_0000, 32'h8001_1234);
    RST = 1'b1;
    #1;
    chk("lh_reset_midload", LOAD_DATA, 32'h0);
    RST = 1'b0;

    drive(32'h0000008F, 32'h0, 32'h0, 32'h0);
    @(posedge CLK);
    #1;
    chk("no_load_data", LOAD_DATA, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
